data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
Shares the single-port, synchronous-read data RAM between the cpu data port and one external master (debug/loader/video DMA). It sequences cpu reads across two cycles by driving the cpu stall input, passes cpu writes through in one cycle, and serves the external master opportunistically or by forced grant after a bounded wait. It sits between cpu, RAM and the external master port.

Parameters:
ADDR_WIDTH, 15, data address width (matches cpu data_addr)
DATA_WIDTH, 16, data word width
MAX_WAIT, 4, max consecutive cycles ext_req may wait before a forced grant (>=1)

Ports:
clk  in  1  clock, rising edge
resetN  in  1  asynchronous active-low reset
cpu_read_m  in  1  cpu read request (cpu read_m)
cpu_write_m  in  1  cpu write strobe (cpu write_m, already gated by stall inside cpu)
cpu_addr  in  ADDR_WIDTH  cpu data_addr
cpu_out_m  in  DATA_WIDTH  cpu write data
cpu_in_m  out  DATA_WIDTH  read data to cpu
cpu_stall  out  1  stall to cpu
ext_req  in  1  external access request, held until granted
ext_we  in  1  1=write, 0=read; valid with ext_req
ext_addr  in  ADDR_WIDTH  external address
ext_wdata  in  DATA_WIDTH  external write data
ext_gnt  out  1  one-cycle grant; access performed this cycle
ext_rvalid  out  1  external read data valid (cycle after read grant)
ext_rdata  out  DATA_WIDTH  external read data
ram_addr  out  ADDR_WIDTH  RAM address
ram_we  out  1  RAM write enable
ram_wdata  out  DATA_WIDTH  RAM write data
ram_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after address

Behaviour:
- States: IDLE, CPU_RD. Registers: state, wait_cnt, ext_rvalid. Reset: state=IDLE, wait_cnt=0, ext_rvalid=0; while resetN low ext_gnt=0, ram_we=0.
- forced = (state==IDLE) && ext_req && (wait_cnt==MAX_WAIT).
- cpu_stall = forced || (state==IDLE && cpu_read_m). Must not depend on cpu_write_m (cpu gates write_m with stall; no combinational loop).
- IDLE, forced: ext_gnt=1, RAM driven from ext_*; cpu stalled; state stays IDLE.
- IDLE, !forced, cpu_read_m: ram_addr=cpu_addr, ram_we=0; -> CPU_RD.
- IDLE, !forced, !cpu_read_m, cpu_write_m: ram_we=1, addr/wdata from cpu, no stall.
- IDLE, no cpu access, ext_req: opportunistic ext_gnt=1, no stall.
- CPU_RD: cpu_stall=0; cpu_in_m=ram_rdata; cpu finishes instruction. If cpu_write_m (read-modify-write, e.g. M=M+1) RAM write from cpu; else ext_req gets opportunistic grant. Always -> IDLE.
- cpu_in_m = ram_rdata in all states (consumed by cpu only in CPU_RD).
- wait_cnt: 0 on ext_gnt or !ext_req; else increments, saturating at MAX_WAIT. Forced grant only in IDLE; in CPU_RD it defers one cycle.
- ext_rvalid <= ext_gnt && !ext_we; ext_rdata = ram_rdata.
- Idle RAM cycles: ram_we=0, ram_addr=cpu_addr.
- Bandwidth: cpu read = 2 cycles; cpu write = 1 cycle; ext worst-case latency MAX_WAIT+2 cycles.
- Reset mid-operation: state returns to IDLE, pending read discarded, ext_rvalid cleared, no RAM write.

Test Plan:
- cpu_read_m=1 addr=0x0010, RAM[0x10]=0xBEEF -> stall 1 cycle, next cycle stall=0, cpu_in_m=0xBEEF, state IDLE.
- cpu_write_m=1 addr=0x0020 data=0x1234, no ext_req -> ram_we=1 same cycle, no stall; RAM[0x20]=0x1234.
- ext read addr=0x0005 (RAM=0x00AA), cpu idle -> ext_gnt same cycle, ext_rvalid=1 next cycle with 0x00AA.
- cpu reads every instruction, ext_req held, MAX_WAIT=4 -> ext served in CPU_RD slots; with cpu write in every CPU_RD, forced grant after 4 waits, cpu_stall=1 that cycle, no cpu write lost.
- read-modify-write M=M+1 at 0x0030 (0x0007) with ext_req pending -> CPU_RD writes 0x0008, ext_gnt deferred to next cycle.
- resetN low during CPU_RD -> state IDLE, ext_rvalid=0, ram_we=0 asynchronously; normal operation after release.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-port data RAM between the cpu
// data port and one external master, with a bounded-wait forced grant.
module data_mem_arbiter #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  cpu_read_m,
    input  logic                  cpu_write_m,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_out_m,
    output logic [DATA_WIDTH-1:0] cpu_in_m,
    output logic                  cpu_stall,
    input  logic                  ext_req,
    input  logic                  ext_we,
    input  logic [ADDR_WIDTH-1:0] ext_addr,
    input  logic [DATA_WIDTH-1:0] ext_wdata,
    output logic                  ext_gnt,
    output logic                  ext_rvalid,
    output logic [DATA_WIDTH-1:0] ext_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] CPU_RD = 1'b1;

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

    logic [0:0]    state_q;
    logic [0:0]    state_d;
    logic [CW-1:0] wait_cnt_q;
    logic [CW-1:0] wait_cnt_d;
    logic          ext_rvalid_q;
    logic          ext_rvalid_d;

    logic          forced;
    logic          gnt_raw;
    logic          we_raw;

    // The external master wins outright once it has waited MAX_WAIT cycles.
    assign forced = (state_q == IDLE) && ext_req && (wait_cnt_q == WAIT_MAX);

    // Stall never looks at cpu_write_m: the cpu gates its write with stall.
    assign cpu_stall = forced || ((state_q == IDLE) && cpu_read_m);

    // Read data goes straight to both masters; each knows when it is valid.
    assign cpu_in_m   = ram_rdata;
    assign ext_rdata  = ram_rdata;
    assign ext_rvalid = ext_rvalid_q;

    // Grants and writes are blocked for as long as reset is held.
    assign ext_gnt = gnt_raw & resetN;
    assign ram_we  = we_raw & resetN;

    // Slot ownership: picks who drives the RAM this cycle and the next state.
    always_comb begin
        state_d   = state_q;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_out_m;
        we_raw    = 1'b0;
        gnt_raw   = 1'b0;
        case (state_q)
            IDLE: begin
                if (forced) begin
                    gnt_raw   = 1'b1;
                    ram_addr  = ext_addr;
                    ram_wdata = ext_wdata;
                    we_raw    = ext_we;
                end else if (cpu_read_m) begin
                    state_d = CPU_RD;
                end else if (cpu_write_m) begin
                    we_raw = 1'b1;
                end else if (ext_req) begin
                    gnt_raw   = 1'b1;
                    ram_addr  = ext_addr;
                    ram_wdata = ext_wdata;
                    we_raw    = ext_we;
                end
            end
            CPU_RD: begin
                state_d = IDLE;
                if (cpu_write_m) begin
                    we_raw = 1'b1;
                end else if (ext_req) begin
                    gnt_raw   = 1'b1;
                    ram_addr  = ext_addr;
                    ram_wdata = ext_wdata;
                    we_raw    = ext_we;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Wait counter saturates so a forced grant stays armed while deferred.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!ext_req || ext_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + CW'(1);
        end
        ext_rvalid_d = ext_gnt && !ext_we;
    end

    // State, wait counter and external read-valid registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            ext_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            ext_rvalid_q <= ext_rvalid_d;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed stimulus with a queue scoreboard for
// cpu reads, RAM writes, external grants and external read data.
module tb_data_mem_arbiter;

    logic        clk;
    logic        resetN;
    logic        cpu_read_m;
    logic        cpu_write_m;
    logic [14:0] cpu_addr;
    logic [15:0] cpu_out_m;
    logic [15:0] cpu_in_m;
    logic        cpu_stall;
    logic        ext_req;
    logic        ext_we;
    logic [14:0] ext_addr;
    logic [15:0] ext_wdata;
    logic        ext_gnt;
    logic        ext_rvalid;
    logic [15:0] ext_rdata;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    logic [15:0] mem [0:32767];

    int n_cmp;
    int n_bad;
    int cyc;

    logic [15:0] exp_cpu [$];
    logic [15:0] exp_ext [$];
    int          exp_gnt [$];
    logic [30:0] exp_wr  [$];

    data_mem_arbiter #(
        .ADDR_WIDTH(15),
        .DATA_WIDTH(16),
        .MAX_WAIT(4)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .cpu_read_m(cpu_read_m),
        .cpu_write_m(cpu_write_m),
        .cpu_addr(cpu_addr),
        .cpu_out_m(cpu_out_m),
        .cpu_in_m(cpu_in_m),
        .cpu_stall(cpu_stall),
        .ext_req(ext_req),
        .ext_we(ext_we),
        .ext_addr(ext_addr),
        .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt),
        .ext_rvalid(ext_rvalid),
        .ext_rdata(ext_rdata),
        .ram_addr(ram_addr),
        .ram_we(ram_we),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic cpu(input logic r, input logic w,
                       input logic [14:0] a, input logic [15:0] d);
        cpu_read_m  = r;
        cpu_write_m = w;
        cpu_addr    = a;
        cpu_out_m   = d;
    endtask

    task automatic ext(input logic req, input logic we,
                       input logic [14:0] a, input logic [15:0] d);
        ext_req   = req;
        ext_we    = we;
        ext_addr  = a;
        ext_wdata = d;
    endtask

    task automatic step(input logic es);
        @(negedge clk);
        chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, es});
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [14:0] a, input logic [15:0] d);
        exp_wr.push_back({a, d});
    endtask

    // Monitor: every DUT output event is matched against the queues.
    always @(negedge clk) begin
        if (ram_we) begin
            if (exp_wr.size() == 0) begin
                chk("unexpected ram_we", 32'd1, 32'd0);
            end else begin
                logic [30:0] w;
                w = exp_wr.pop_front();
                chk("ram_addr", {17'd0, ram_addr}, {17'd0, w[30:16]});
                chk("ram_wdata", {16'd0, ram_wdata}, {16'd0, w[15:0]});
            end
        end
        if (ext_gnt) begin
            if (exp_gnt.size() == 0) chk("unexpected ext_gnt", 32'd1, 32'd0);
            else chk("ext_gnt cycle", cyc, exp_gnt.pop_front());
        end
        if (ext_rvalid) begin
            if (exp_ext.size() == 0) chk("unexpected ext_rvalid", 32'd1, 32'd0);
            else chk("ext_rdata", {16'd0, ext_rdata}, {16'd0, exp_ext.pop_front()});
        end
        if (cpu_read_m && !cpu_stall) begin
            if (exp_cpu.size() == 0) chk("unexpected cpu data", 32'd1, 32'd0);
            else chk("cpu_in_m", {16'd0, cpu_in_m}, {16'd0, exp_cpu.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        cyc    = 0;
        resetN = 1'b0;
        cpu(1'b0, 1'b1, 15'h0007, 16'h1111);
        ext(1'b1, 1'b1, 15'h0007, 16'h2222);

        // Reset: requests present but nothing may be granted or written.
        @(negedge clk);
        chk("rst ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst ext_gnt", {31'd0, ext_gnt}, 32'd0);
        chk("rst ext_rvalid", {31'd0, ext_rvalid}, 32'd0);
        chk("rst cpu_stall", {31'd0, cpu_stall}, 32'd0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        cpu(1'b0, 1'b0, 15'h0, 16'h0);
        ext(1'b0, 1'b0, 15'h0, 16'h0);

        // Single-cycle cpu writes, no stall.
        cpu(1'b0, 1'b1, 15'h0020, 16'h1234); push_wr(15'h0020, 16'h1234); step(1'b0);
        cpu(1'b0, 1'b1, 15'h0010, 16'hBEEF); push_wr(15'h0010, 16'hBEEF); step(1'b0);
        cpu(1'b0, 1'b1, 15'h0005, 16'h00AA); push_wr(15'h0005, 16'h00AA); step(1'b0);
        cpu(1'b0, 1'b1, 15'h0030, 16'h0007); push_wr(15'h0030, 16'h0007); step(1'b0);
        cpu(1'b0, 1'b0, 15'h0, 16'h0); step(1'b0);

        // Two-cycle cpu reads.
        cpu(1'b1, 1'b0, 15'h0010, 16'h0); step(1'b1);
        exp_cpu.push_back(16'hBEEF); step(1'b0);
        cpu(1'b0, 1'b0, 15'h0, 16'h0); step(1'b0);
        cpu(1'b1, 1'b0, 15'h0020, 16'h0); step(1'b1);
        exp_cpu.push_back(16'h1234); step(1'b0);
        cpu(1'b0, 1'b0, 15'h0, 16'h0);

        // External read while cpu idle: grant now, data next cycle.
        ext(1'b1, 1'b0, 15'h0005, 16'h0);
        exp_gnt.push_back(cyc); exp_ext.push_back(16'h00AA); step(1'b0);
        ext(1'b0, 1'b0, 15'h0, 16'h0); step(1'b0);

        // External read served in the CPU_RD slot of a plain cpu read.
        cpu(1'b1, 1'b0, 15'h0010, 16'h0); ext(1'b1, 1'b0, 15'h0005, 16'h0); step(1'b1);
        exp_cpu.push_back(16'hBEEF);
        exp_gnt.push_back(cyc); exp_ext.push_back(16'h00AA); step(1'b0);
        cpu(1'b0, 1'b0, 15'h0, 16'h0); ext(1'b0, 1'b0, 15'h0, 16'h0); step(1'b0);

        // Read-modify-write with ext pending: grant deferred one cycle.
        cpu(1'b1, 1'b0, 15'h0030, 16'h0); ext(1'b1, 1'b0, 15'h0020, 16'h0); step(1'b1);
        cpu(1'b1, 1'b1, 15'h0030, 16'h0008);
        exp_cpu.push_back(16'h0007); push_wr(15'h0030, 16'h0008); step(1'b0);
        cpu(1'b0, 1'b0, 15'h0, 16'h0);
        exp_gnt.push_back(cyc); exp_ext.push_back(16'h1234); step(1'b0);
        ext(1'b0, 1'b0, 15'h0, 16'h0); step(1'b0);

        // Back-to-back cpu read+write: ext write forced after 4 waits.
        ext(1'b1, 1'b1, 15'h0040, 16'h5A5A);
        exp_gnt.push_back(cyc + 4);
        cpu(1'b1, 1'b0, 15'h0020, 16'h0); step(1'b1);
        cpu(1'b1, 1'b1, 15'h0020, 16'h1235);
        exp_cpu.push_back(16'h1234); push_wr(15'h0020, 16'h1235); step(1'b0);
        cpu(1'b1, 1'b0, 15'h0020, 16'h0); step(1'b1);
        cpu(1'b1, 1'b1, 15'h0020, 16'h1236);
        exp_cpu.push_back(16'h1235); push_wr(15'h0020, 16'h1236); step(1'b0);
        cpu(1'b1, 1'b0, 15'h0020, 16'h0);
        push_wr(15'h0040, 16'h5A5A); step(1'b1);
        ext(1'b0, 1'b0, 15'h0, 16'h0);
        cpu(1'b1, 1'b0, 15'h0020, 16'h0); step(1'b1);
        cpu(1'b1, 1'b1, 15'h0020, 16'h1237);
        exp_cpu.push_back(16'h1236); push_wr(15'h0020, 16'h1237); step(1'b0);
        cpu(1'b0, 1'b0, 15'h0, 16'h0);
        ext(1'b1, 1'b0, 15'h0040, 16'h0);
        exp_gnt.push_back(cyc); exp_ext.push_back(16'h5A5A); step(1'b0);
        ext(1'b0, 1'b0, 15'h0, 16'h0); step(1'b0);
        cpu(1'b1, 1'b0, 15'h0020, 16'h0); step(1'b1);
        exp_cpu.push_back(16'h1237); step(1'b0);
        cpu(1'b0, 1'b0, 15'h0, 16'h0); step(1'b0);

        // Reset asserted during CPU_RD: write and grant suppressed.
        cpu(1'b1, 1'b0, 15'h0030, 16'h0); step(1'b1);
        cpu(1'b1, 1'b1, 15'h0030, 16'hDEAD);
        ext(1'b1, 1'b0, 15'h0005, 16'h0);
        #1;
        resetN = 1'b0;
        @(negedge clk);
        chk("midrst ram_we", {31'd0, ram_we}, 32'd0);
        chk("midrst ext_gnt", {31'd0, ext_gnt}, 32'd0);
        chk("midrst ext_rvalid", {31'd0, ext_rvalid}, 32'd0);
        chk("midrst stall(idle)", {31'd0, cpu_stall}, 32'd1);
        @(posedge clk);
        #1;
        cpu(1'b0, 1'b0, 15'h0, 16'h0);
        ext(1'b0, 1'b0, 15'h0, 16'h0);
        resetN = 1'b1;
        step(1'b0);
        cpu(1'b1, 1'b0, 15'h0030, 16'h0); step(1'b1);
        exp_cpu.push_back(16'h0008); step(1'b0);
        cpu(1'b0, 1'b0, 15'h0, 16'h0); step(1'b0);
        step(1'b0);

        chk("exp_cpu drained", exp_cpu.size(), 32'd0);
        chk("exp_ext drained", exp_ext.size(), 32'd0);
        chk("exp_gnt drained", exp_gnt.size(), 32'd0);
        chk("exp_wr drained", exp_wr.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
